// File: rtl/riscv_bpu_pkg.sv
// Shared types and constants for the branch prediction unit.
//   ctr_t      : 2-bit saturating direction counter encoding
//   CTR_RESET  : counter value written to every entry on reset
//   CTR_ALLOC  : counter value written when a taken branch allocates an entry
//   ctr_next() : saturating counter step towards the resolved outcome
package riscv_bpu_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WEAK_NT;
    localparam ctr_t CTR_ALLOC = WEAK_T;

    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        case (cur)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = CTR_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/riscv_bpu_table.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   rd_pc                 : word address (pc[XLEN-1:2]) to look up, async read
//   rd_taken, rd_target   : prediction from registered state (target 0 if not taken)
//   wr_en                 : a branch resolves this cycle
//   wr_pc                 : word address of the resolving branch
//   wr_taken, wr_target   : resolved outcome and taken target
import riscv_bpu_pkg::*;

module riscv_bpu_table #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned XLEN    = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:2] rd_pc,
    output logic            rd_taken,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [XLEN-1:2] wr_pc,
    input  logic            wr_taken,
    input  logic [XLEN-1:0] wr_target
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [XLEN-1:0]    target [ENTRIES];
    ctr_t               ctr    [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             rd_hit;
    logic             wr_hit;

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[XLEN-1:IDX_W+2];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[XLEN-1:IDX_W+2];

    // Lookup sees registered contents only, so a same-index write this
    // cycle is not visible until the next cycle.
    always_comb begin
        rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
        rd_taken  = rd_hit && ctr[rd_idx][1];
        rd_target = rd_taken ? target[rd_idx] : '0;
        wr_hit    = valid[wr_idx] && (tag[wr_idx] == wr_tag);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid  <= '0;
            tag    <= '{default: '0};
            target <= '{default: '0};
            ctr    <= '{default: CTR_RESET};
        end else if (wr_en) begin
            if (wr_hit) begin
                ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
                if (wr_taken) begin
                    target[wr_idx] <= wr_target;
                end
            end else if (wr_taken) begin
                // Taken miss evicts whatever occupies the slot.
                valid[wr_idx]  <= 1'b1;
                tag[wr_idx]    <= wr_tag;
                target[wr_idx] <= wr_target;
                ctr[wr_idx]    <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: rtl/riscv_bpu.sv
// Branch prediction unit: IF-stage lookup, EX-stage resolution, mispredict
// flush/redirect and a free-running mispredict counter.
// Ports:
//   i_riscv_bpu_clk, i_riscv_bpu_rst_n   : clock, synchronous active-low reset
//   i_riscv_bpu_if_pc                    : fetch PC to predict
//   o_riscv_bpu_pred_taken/_pred_target  : prediction (target 0 when not taken)
//   i_riscv_bpu_ex_*                     : EX-stage branch information
//   o_riscv_bpu_flush, _redirect_pc      : zero-latency mispredict redirect
//   o_riscv_bpu_mispred_cnt              : wrapping mispredict count
import riscv_bpu_pkg::*;

module riscv_bpu #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned XLEN    = 64
) (
    input  logic            i_riscv_bpu_clk,
    input  logic            i_riscv_bpu_rst_n,
    input  logic [XLEN-1:0] i_riscv_bpu_if_pc,
    output logic            o_riscv_bpu_pred_taken,
    output logic [XLEN-1:0] o_riscv_bpu_pred_target,
    input  logic            i_riscv_bpu_ex_valid,
    input  logic            i_riscv_bpu_ex_isbranch,
    input  logic            i_riscv_bpu_ex_stall,
    input  logic [XLEN-1:0] i_riscv_bpu_ex_pc,
    input  logic            i_riscv_bpu_ex_taken,
    input  logic [XLEN-1:0] i_riscv_bpu_ex_target,
    input  logic            i_riscv_bpu_ex_predtaken,
    input  logic [XLEN-1:0] i_riscv_bpu_ex_predtarget,
    output logic            o_riscv_bpu_flush,
    output logic [XLEN-1:0] o_riscv_bpu_redirect_pc,
    output logic [31:0]     o_riscv_bpu_mispred_cnt
);

    logic        resolve;
    logic        mispredict;
    logic [31:0] mispred_cnt;
    logic        unused_if_pc_lsbs;

    assign unused_if_pc_lsbs = ^i_riscv_bpu_if_pc[1:0];

    // Reset masks resolution so a branch resolving in a reset cycle
    // neither flushes nor counts.
    always_comb begin
        resolve    = i_riscv_bpu_rst_n && i_riscv_bpu_ex_valid &&
                     i_riscv_bpu_ex_isbranch && !i_riscv_bpu_ex_stall;
        mispredict = resolve &&
                     ((i_riscv_bpu_ex_taken != i_riscv_bpu_ex_predtaken) ||
                      (i_riscv_bpu_ex_taken && i_riscv_bpu_ex_predtaken &&
                       (i_riscv_bpu_ex_target != i_riscv_bpu_ex_predtarget)));
        o_riscv_bpu_flush       = mispredict;
        o_riscv_bpu_redirect_pc = '0;
        if (mispredict) begin
            o_riscv_bpu_redirect_pc = i_riscv_bpu_ex_taken ? i_riscv_bpu_ex_target
                                                           : i_riscv_bpu_ex_pc + XLEN'(4);
        end
    end

    always_ff @(posedge i_riscv_bpu_clk) begin
        if (!i_riscv_bpu_rst_n) begin
            mispred_cnt <= '0;
        end else if (mispredict) begin
            mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    assign o_riscv_bpu_mispred_cnt = mispred_cnt;

    riscv_bpu_table #(
        .ENTRIES(ENTRIES),
        .XLEN   (XLEN)
    ) u_table (
        .clk      (i_riscv_bpu_clk),
        .rst_n    (i_riscv_bpu_rst_n),
        .rd_pc    (i_riscv_bpu_if_pc[XLEN-1:2]),
        .rd_taken (o_riscv_bpu_pred_taken),
        .rd_target(o_riscv_bpu_pred_target),
        .wr_en    (resolve),
        .wr_pc    (i_riscv_bpu_ex_pc[XLEN-1:2]),
        .wr_taken (i_riscv_bpu_ex_taken),
        .wr_target(i_riscv_bpu_ex_target)
    );

endmodule

// File: tb/tb_riscv_bpu.sv
// Self-checking bench for riscv_bpu: per-cycle comparison against an
// array-based predictor model, plus hand-computed literal expectations.
module tb_riscv_bpu;

    localparam int unsigned ENTRIES = 64;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned IDX_W   = $clog2(ENTRIES);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid, ex_isbranch, ex_stall, ex_taken, ex_predtaken;
    logic [XLEN-1:0] ex_pc, ex_target, ex_predtarget;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     mispred_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_bpu #(
        .ENTRIES(ENTRIES),
        .XLEN   (XLEN)
    ) dut (
        .i_riscv_bpu_clk          (clk),
        .i_riscv_bpu_rst_n        (rst_n),
        .i_riscv_bpu_if_pc        (if_pc),
        .o_riscv_bpu_pred_taken   (pred_taken),
        .o_riscv_bpu_pred_target  (pred_target),
        .i_riscv_bpu_ex_valid     (ex_valid),
        .i_riscv_bpu_ex_isbranch  (ex_isbranch),
        .i_riscv_bpu_ex_stall     (ex_stall),
        .i_riscv_bpu_ex_pc        (ex_pc),
        .i_riscv_bpu_ex_taken     (ex_taken),
        .i_riscv_bpu_ex_target    (ex_target),
        .i_riscv_bpu_ex_predtaken (ex_predtaken),
        .i_riscv_bpu_ex_predtarget(ex_predtarget),
        .o_riscv_bpu_flush        (flush),
        .o_riscv_bpu_redirect_pc  (redirect_pc),
        .o_riscv_bpu_mispred_cnt  (mispred_cnt)
    );

    // ---------------- model ----------------
    bit              m_valid [ENTRIES];
    logic [XLEN-1:0] m_tag   [ENTRIES];
    logic [XLEN-1:0] m_tgt   [ENTRIES];
    int              m_ctr   [ENTRIES];
    logic [31:0]     m_cnt;
    bit              model_ok = 0;

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit m_resolve();
        return rst_n && ex_valid && ex_isbranch && !ex_stall;
    endfunction

    function automatic bit m_mispred();
        return m_resolve() && ((ex_taken != ex_predtaken) ||
               (ex_taken && ex_predtaken && ex_target != ex_predtarget));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
            end
            m_cnt    = 32'd0;
            model_ok = 1;
        end else if (m_resolve()) begin
            int k;
            k = idx_of(ex_pc);
            if (m_mispred()) m_cnt = m_cnt + 32'd1;
            if (m_valid[k] && m_tag[k] == tag_of(ex_pc)) begin
                if (ex_taken) begin
                    m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                    m_tgt[k] = ex_target;
                end else begin
                    m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
                end
            end else if (ex_taken) begin
                m_valid[k] = 1; m_tag[k] = tag_of(ex_pc);
                m_tgt[k] = ex_target; m_ctr[k] = 2;
            end
        end
    end

    function automatic void chk(input string name, input logic [XLEN-1:0] act,
                                input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            int k;
            bit e_taken, e_flush;
            logic [XLEN-1:0] e_tgt, e_redir;
            k       = idx_of(if_pc);
            e_taken = m_valid[k] && m_tag[k] == tag_of(if_pc) && m_ctr[k] >= 2;
            e_tgt   = e_taken ? m_tgt[k] : '0;
            e_flush = m_mispred();
            e_redir = !e_flush ? '0 : (ex_taken ? ex_target : ex_pc + 64'd4);
            chk("model_pred_taken", {63'd0, pred_taken}, {63'd0, e_taken});
            chk("model_pred_target", pred_target, e_tgt);
            chk("model_flush", {63'd0, flush}, {63'd0, e_flush});
            chk("model_redirect", redirect_pc, e_redir);
            chk("model_mispred_cnt", {32'd0, mispred_cnt}, {32'd0, m_cnt});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rst, input logic [XLEN-1:0] ipc,
                        input logic v, input logic br, input logic st,
                        input logic [XLEN-1:0] pc, input logic tk,
                        input logic [XLEN-1:0] tgt, input logic pt,
                        input logic [XLEN-1:0] ptgt);
        @(posedge clk);
        #1;
        rst_n = rst; if_pc = ipc;
        ex_valid = v; ex_isbranch = br; ex_stall = st; ex_pc = pc;
        ex_taken = tk; ex_target = tgt; ex_predtaken = pt; ex_predtarget = ptgt;
        @(negedge clk);
    endtask

    task automatic idle(input logic rst, input logic [XLEN-1:0] ipc);
        step(rst, ipc, 0, 0, 0, '0, 0, '0, 0, '0);
    endtask

    initial begin
        rst_n = 0; if_pc = '0; ex_valid = 0; ex_isbranch = 0; ex_stall = 0;
        ex_pc = '0; ex_taken = 0; ex_target = '0; ex_predtaken = 0; ex_predtarget = '0;
        idle(0, 64'h1000);
        idle(0, 64'h1000);

        // Cold lookup after reset
        idle(1, 64'h1000);
        chk("cold_pred_taken", {63'd0, pred_taken}, 64'd0);
        chk("cold_pred_target", pred_target, 64'd0);
        chk("cold_flush", {63'd0, flush}, 64'd0);
        chk("cold_cnt", {32'd0, mispred_cnt}, 64'd0);

        // First taken resolve allocates and flushes
        step(1, 64'h1000, 1, 1, 0, 64'h1000, 1, 64'h2000, 0, '0);
        chk("alloc_flush", {63'd0, flush}, 64'd1);
        chk("alloc_redirect", redirect_pc, 64'h2000);
        idle(1, 64'h1000);
        chk("alloc_pred_taken", {63'd0, pred_taken}, 64'd1);
        chk("alloc_pred_target", pred_target, 64'h2000);
        chk("alloc_cnt", {32'd0, mispred_cnt}, 64'd1);

        // Two not-taken resolves: 10 -> 01 -> 00
        step(1, 64'h1000, 1, 1, 0, 64'h1000, 0, '0, 1, 64'h2000);
        chk("nt1_pre_update_lookup", {63'd0, pred_taken}, 64'd1);
        chk("nt1_flush", {63'd0, flush}, 64'd1);
        chk("nt1_redirect", redirect_pc, 64'h1004);
        step(1, 64'h1000, 1, 1, 0, 64'h1000, 0, '0, 0, '0);
        chk("nt2_flush", {63'd0, flush}, 64'd0);
        chk("nt2_pred_taken", {63'd0, pred_taken}, 64'd0);
        idle(1, 64'h1000);
        chk("nt_pred_taken", {63'd0, pred_taken}, 64'd0);

        // Saturate at 11, then one not-taken leaves it at 10
        for (int n = 0; n < 4; n++)
            step(1, 64'h1000, 1, 1, 0, 64'h1000, 1, 64'h2000, 1, 64'h2000);
        step(1, 64'h1000, 1, 1, 0, 64'h1000, 0, '0, 1, 64'h2000);
        chk("sat_nt_redirect", redirect_pc, 64'h1004);
        idle(1, 64'h1000);
        chk("sat_pred_taken", {63'd0, pred_taken}, 64'd1);
        chk("sat_pred_target", pred_target, 64'h2000);

        // Aliasing: 0x1000 + 4*ENTRIES shares the index
        step(1, 64'h1000, 1, 1, 0, 64'h1100, 1, 64'h3000, 0, '0);
        idle(1, 64'h1000);
        chk("alias_old_miss", {63'd0, pred_taken}, 64'd0);
        idle(1, 64'h1100);
        chk("alias_new_target", pred_target, 64'h3000);

        // Stalled resolve with a target mispredict
        for (int n = 0; n < 2; n++) begin
            step(1, 64'h1100, 1, 1, 1, 64'h1100, 1, 64'h3800, 1, 64'h3000);
            chk("stall_no_flush", {63'd0, flush}, 64'd0);
        end
        idle(1, 64'h1100);
        chk("stall_no_update", pred_target, 64'h3000);
        step(1, 64'h1100, 1, 1, 0, 64'h1100, 1, 64'h3800, 1, 64'h3000);
        chk("unstall_flush", {63'd0, flush}, 64'd1);
        chk("unstall_redirect", redirect_pc, 64'h3800);
        idle(1, 64'h1100);
        chk("target_overwrite", pred_target, 64'h3800);

        // Non-branch never flushes or updates
        step(1, 64'h1100, 1, 0, 0, 64'h1100, 1, 64'h9000, 0, '0);
        chk("nonbr_flush", {63'd0, flush}, 64'd0);
        chk("nonbr_redirect", redirect_pc, 64'd0);
        idle(1, 64'h1100);
        chk("nonbr_target", pred_target, 64'h3800);

        // Counter wrap
        #2;
        force dut.mispred_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.mispred_cnt;
        step(1, 64'h1100, 1, 1, 0, 64'h1100, 0, '0, 1, 64'h3800);
        chk("wrap_pre", {32'd0, mispred_cnt}, 64'hFFFF_FFFF);
        idle(1, 64'h1100);
        chk("wrap_zero", {32'd0, mispred_cnt}, 64'd0);

        // Reset coinciding with a resolving taken branch
        step(0, 64'h4000, 1, 1, 0, 64'h4000, 1, 64'h5000, 0, '0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_redirect", redirect_pc, 64'd0);
        idle(1, 64'h4000);
        chk("rst_no_alloc", {63'd0, pred_taken}, 64'd0);
        chk("rst_cnt", {32'd0, mispred_cnt}, 64'd0);
        idle(1, 64'h1100);
        chk("rst_cleared", {63'd0, pred_taken}, 64'd0);

        idle(1, 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
